// File: rtl/spart_driver.sv
// SPART driver: programs the baud divisor from br_cfg, then echoes received bytes through a 4-deep FIFO.
// Optional build macro SPART_DRV_UPCASE_EN folds received 'a'..'z' to 'A'..'Z' before storing.
module spart_driver (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] br_cfg,
  output logic       iocs,
  output logic       iorw,
  output logic [1:0] ioaddr,
  inout  logic [7:0] databus,
  input  logic       rda,
  input  logic       tbr,
  output logic       cfg_done,
  output logic [2:0] fifo_cnt
);

  typedef enum logic [2:0] {
    CFG_LO,
    CFG_HI,
    POLL,
    RX_RD,
    TX_WR
  } state_t;

  localparam logic [1:0] ADDR_BUF    = 2'b00;
  localparam logic [1:0] ADDR_DIV_LO = 2'b10;
  localparam logic [1:0] ADDR_DIV_HI = 2'b11;

  state_t      r_state;
  state_t      w_next;
  logic        r_run;
  logic [1:0]  r_br;
  logic        r_cfg_done;
  logic [7:0]  r_mem [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_cnt;

  logic [1:0]  w_div_sel;
  logic [15:0] w_div;
  logic [7:0]  w_wdata;
  logic [7:0]  w_rx_byte;
  logic        w_push;
  logic        w_pop;
  logic        w_set_cfg;
  logic        w_clr_cfg;

  function automatic logic [15:0] divisor(input logic [1:0] sel);
    case (sel)
      2'b00:   return 16'h028A;
      2'b01:   return 16'h0145;
      2'b10:   return 16'h00A2;
      default: return 16'h0050;
    endcase
  endfunction

  // The low byte uses the live br_cfg (latched on the same edge); the high byte uses the latched copy.
  always_comb begin
    w_div_sel = (r_state == CFG_LO) ? br_cfg : r_br;
    w_div     = divisor(w_div_sel);
  end

`ifdef SPART_DRV_UPCASE_EN
  always_comb begin
    w_rx_byte = databus;
    if (databus >= 8'h61 && databus <= 8'h7A) begin
      w_rx_byte = databus - 8'h20;
    end
  end
`else
  always_comb begin
    w_rx_byte = databus;
  end
`endif

  always_comb begin
    w_next    = r_state;
    iocs      = 1'b0;
    iorw      = 1'b1;
    ioaddr    = ADDR_BUF;
    w_wdata   = '0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_set_cfg = 1'b0;
    w_clr_cfg = 1'b0;
    case (r_state)
      CFG_LO: begin
        // r_run holds off the first access until one clean edge out of reset.
        if (r_run) begin
          iocs    = 1'b1;
          iorw    = 1'b0;
          ioaddr  = ADDR_DIV_LO;
          w_wdata = w_div[7:0];
          w_next  = CFG_HI;
        end
      end
      CFG_HI: begin
        iocs      = 1'b1;
        iorw      = 1'b0;
        ioaddr    = ADDR_DIV_HI;
        w_wdata   = w_div[15:8];
        w_set_cfg = 1'b1;
        w_next    = POLL;
      end
      POLL: begin
        if (br_cfg != r_br) begin
          w_clr_cfg = 1'b1;
          w_next    = CFG_LO;
        end else if (rda && (r_cnt < 3'd4)) begin
          w_next = RX_RD;
        end else if (tbr && (r_cnt != 3'd0)) begin
          w_next = TX_WR;
        end
      end
      RX_RD: begin
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = ADDR_BUF;
        w_push = 1'b1;
        w_next = POLL;
      end
      TX_WR: begin
        iocs    = 1'b1;
        iorw    = 1'b0;
        ioaddr  = ADDR_BUF;
        w_wdata = r_mem[r_rd_ptr];
        w_pop   = 1'b1;
        w_next  = POLL;
      end
      default: w_next = CFG_LO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= CFG_LO;
      r_run      <= 1'b0;
      r_br       <= '0;
      r_cfg_done <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_next;
      r_run   <= 1'b1;
      if (r_state == CFG_LO && r_run) begin
        r_br <= br_cfg;
      end
      if (w_set_cfg) begin
        r_cfg_done <= 1'b1;
      end else if (w_clr_cfg) begin
        r_cfg_done <= 1'b0;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wr_ptr] <= w_rx_byte;
    end
  end

  assign databus  = (iocs && !iorw) ? w_wdata : 'z;
  assign cfg_done = r_cfg_done;
  assign fifo_cnt = r_cnt;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: models the SPART side and checks every bus cycle against the access rules.
// Build with SPART_DRV_UPCASE_EN defined to check the uppercase-folding variant.
module tb_spart_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] br_cfg;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  wire  [7:0] databus;
  logic       rda;
  logic       tbr;
  logic       cfg_done;
  logic [2:0] fifo_cnt;
  logic [7:0] spart_out;

  assign databus = (iocs && iorw) ? spart_out : 8'hzz;

  always #5 clk = ~clk;

  spart_driver dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .br_cfg   (br_cfg),
    .iocs     (iocs),
    .iorw     (iorw),
    .ioaddr   (ioaddr),
    .databus  (databus),
    .rda      (rda),
    .tbr      (tbr),
    .cfg_done (cfg_done),
    .fifo_cnt (fifo_cnt)
  );

  localparam int K_RESET = 0;
  localparam int K_IDLE  = 1;
  localparam int K_RD    = 2;
  localparam int K_WR    = 3;
  localparam int K_LO    = 4;
  localparam int K_HI    = 5;
  localparam int K_BAD   = 6;

  int unsigned n_checks;
  int unsigned n_errors;
  logic [7:0]  q_rx[$];
  logic [7:0]  model_fifo[$];
  logic [7:0]  tx_log[$];
  int          prev_kind;
  logic [7:0]  prev_wdata;
  logic [1:0]  latched_br;
  logic        rda_en;
  logic [7:0]  rb;
  logic [7:0]  exp61;

  function automatic logic [15:0] div_of(input logic [1:0] b);
    case (b)
      2'd0:    return 16'd650;
      2'd1:    return 16'd325;
      2'd2:    return 16'd162;
      default: return 16'd80;
    endcase
  endfunction

  function automatic logic [7:0] xform(input logic [7:0] b);
`ifdef SPART_DRV_UPCASE_EN
    if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
`endif
    return b;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    rda       = rda_en && (q_rx.size() > 0);
    spart_out = (q_rx.size() > 0) ? q_rx[0] : 8'h00;
  endtask

  task automatic spart_push(input logic [7:0] b);
    q_rx.push_back(b);
    refresh();
  endtask

  // One clock: commit the previous cycle's access, then check the new cycle against the rules.
  task automatic cycle();
    logic       e_rst;
    logic       e_rda;
    logic       e_tbr;
    logic [1:0] e_br;
    int         exp_kind;
    int         kind;
    int         cnt;
    logic [15:0] d;
    @(posedge clk);
    e_rst = rst_n;
    e_rda = rda;
    e_tbr = tbr;
    e_br  = br_cfg;
    #1;
    if (!e_rst) begin
      model_fifo.delete();
      prev_kind = K_RESET;
      chk("reset_outputs", 32'({iocs, iorw, ioaddr, cfg_done, fifo_cnt}), 32'h40);
      refresh();
      return;
    end
    if (prev_kind == K_RD && q_rx.size() > 0) begin
      model_fifo.push_back(xform(q_rx.pop_front()));
    end else if (prev_kind == K_WR && model_fifo.size() > 0) begin
      void'(model_fifo.pop_front());
      tx_log.push_back(prev_wdata);
    end
    refresh();
    cnt = model_fifo.size();
    case (prev_kind)
      K_RESET: exp_kind = K_LO;
      K_LO:    exp_kind = K_HI;
      K_IDLE: begin
        if (e_br != latched_br)         exp_kind = K_LO;
        else if (e_rda && cnt < 4)      exp_kind = K_RD;
        else if (e_tbr && cnt > 0)      exp_kind = K_WR;
        else                            exp_kind = K_IDLE;
      end
      default: exp_kind = K_IDLE;
    endcase
    if (!iocs)            kind = K_IDLE;
    else if (iorw)        kind = K_RD;
    else if (ioaddr == 2'b00) kind = K_WR;
    else if (ioaddr == 2'b10) kind = K_LO;
    else if (ioaddr == 2'b11) kind = K_HI;
    else                  kind = K_BAD;
    chk("access_kind", 32'(kind), 32'(exp_kind));
    chk("fifo_cnt", 32'(fifo_cnt), 32'(cnt));
    case (kind)
      K_IDLE: begin
        chk("idle_iorw_ioaddr", 32'({iorw, ioaddr}), 32'h4);
        chk("idle_cfg_done", 32'(cfg_done), 32'h1);
      end
      K_LO: begin
        d = div_of(br_cfg);
        chk("cfg_lo_data", 32'(databus), 32'(d[7:0]));
        chk("cfg_lo_cfg_done", 32'(cfg_done), 32'h0);
        latched_br = br_cfg;
      end
      K_HI: begin
        d = div_of(latched_br);
        chk("cfg_hi_data", 32'(databus), 32'(d[15:8]));
        chk("cfg_hi_cfg_done", 32'(cfg_done), 32'h0);
      end
      K_RD: begin
        chk("rd_ioaddr", 32'(ioaddr), 32'h0);
        chk("rd_cfg_done", 32'(cfg_done), 32'h1);
      end
      K_WR: begin
        chk("wr_cfg_done", 32'(cfg_done), 32'h1);
        if (model_fifo.size() > 0) chk("wr_data", 32'(databus), 32'(model_fifo[0]));
        prev_wdata = databus;
      end
      default: ;
    endcase
    prev_kind = kind;
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    prev_kind  = K_RESET;
    prev_wdata = '0;
    latched_br = '0;
    rst_n      = 1'b0;
    br_cfg     = 2'b01;
    tbr        = 1'b0;
    rda_en     = 1'b1;
    refresh();

    // Reset, then divisor programming for 9600 baud.
    repeat (3) cycle();
    rst_n = 1'b1;
    cycle();
    chk("req031_lo", 32'({ioaddr, databus}), 32'({2'b10, 8'h45}));
    cycle();
    chk("req031_hi", 32'({ioaddr, databus}), 32'({2'b11, 8'h01}));
    cycle();
    chk("req031_cfg_done", 32'(cfg_done), 32'h1);

    // Single byte read then echoed.
    tbr = 1'b1;
    spart_push(8'h41);
    cycle();
    chk("req032_read", 32'({iocs, iorw, ioaddr}), 32'b1100);
    cycle();
    chk("req032_cnt1", 32'(fifo_cnt), 32'h1);
    cycle();
    chk("req032_write", 32'({iocs, iorw, ioaddr, databus}), 32'({4'b1000, 8'h41}));
    cycle();
    chk("req032_cnt0", 32'(fifo_cnt), 32'h0);

    // Fill the FIFO; the fifth byte must stay in the SPART.
    tbr = 1'b0;
    tx_log.delete();
    for (int i = 0; i < 5; i++) spart_push(8'(8'h10 + i));
    repeat (16) cycle();
    chk("req033_full_cnt", 32'(fifo_cnt), 32'h4);
    chk("req033_fifth_pending", 32'(q_rx.size()), 32'h1);
    tbr = 1'b1;
    for (int k = 0; k < 60 && !(q_rx.size() == 0 && model_fifo.size() == 0 && fifo_cnt == 3'd0); k++) cycle();
    chk("req033_echo_count", 32'(tx_log.size()), 32'h5);
    for (int i = 0; i < 5 && i < tx_log.size(); i++) chk("req033_echo_order", 32'(tx_log[i]), 32'(8'h10 + i));

    // Baud change with two bytes buffered.
    tbr = 1'b0;
    tx_log.delete();
    spart_push(8'h21);
    spart_push(8'h22);
    repeat (8) cycle();
    chk("req034_cnt_before", 32'(fifo_cnt), 32'h2);
    br_cfg = 2'b11;
    cycle();
    chk("req034_lo", 32'({cfg_done, ioaddr, databus}), 32'({1'b0, 2'b10, 8'h50}));
    cycle();
    chk("req034_hi", 32'({cfg_done, ioaddr, databus}), 32'({1'b0, 2'b11, 8'h00}));
    cycle();
    chk("req034_done", 32'({cfg_done, fifo_cnt}), 32'({1'b1, 3'd2}));
    tbr = 1'b1;
    for (int k = 0; k < 30 && !(model_fifo.size() == 0 && fifo_cnt == 3'd0); k++) cycle();
    chk("req034_echo_count", 32'(tx_log.size()), 32'h2);
    if (tx_log.size() == 2) chk("req034_echo", 32'({tx_log[0], tx_log[1]}), 32'h2122);

    // Case folding build option.
`ifdef SPART_DRV_UPCASE_EN
    exp61 = 8'h41;
`else
    exp61 = 8'h61;
`endif
    tx_log.delete();
    spart_push(8'h61);
    spart_push(8'h5B);
    for (int k = 0; k < 30 && !(q_rx.size() == 0 && model_fifo.size() == 0 && fifo_cnt == 3'd0); k++) cycle();
    chk("req035_count", 32'(tx_log.size()), 32'h2);
    if (tx_log.size() == 2) begin
      chk("req035_0x61", 32'(tx_log[0]), 32'(exp61));
      chk("req035_0x5B", 32'(tx_log[1]), 32'h5B);
    end

    // Reset during a read: FIFO discarded, unread byte stays in the SPART.
    tbr = 1'b0;
    tx_log.delete();
    spart_push(8'h31);
    spart_push(8'h32);
    spart_push(8'h33);
    for (int k = 0; k < 30 && !(fifo_cnt == 3'd2 && iocs && iorw); k++) cycle();
    chk("req028_in_read", 32'({fifo_cnt, iocs, iorw}), 32'({3'd2, 2'b11}));
    rst_n = 1'b0;
    cycle();
    chk("req028_pending", 32'(q_rx.size()), 32'h1);
    cycle();
    rst_n = 1'b1;
    tbr   = 1'b1;
    for (int k = 0; k < 30 && !(q_rx.size() == 0 && model_fifo.size() == 0 && fifo_cnt == 3'd0); k++) cycle();
    chk("req028_echo_count", 32'(tx_log.size()), 32'h1);
    if (tx_log.size() == 1) chk("req028_echo", 32'(tx_log[0]), 32'h33);

    // Randomized traffic checked cycle by cycle.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0 && q_rx.size() < 6) begin
        case ($urandom_range(0, 5))
          0:       rb = 8'h60;
          1:       rb = 8'h61;
          2:       rb = 8'h7A;
          3:       rb = 8'h7B;
          default: rb = 8'($urandom);
        endcase
        spart_push(rb);
      end
      tbr    = 1'($urandom_range(0, 1));
      rda_en = ($urandom_range(0, 7) != 0);
      refresh();
      if ($urandom_range(0, 59) == 0) br_cfg = 2'($urandom_range(0, 3));
      cycle();
    end
    rda_en = 1'b1;
    tbr    = 1'b1;
    refresh();
    for (int k = 0; k < 80 && !(q_rx.size() == 0 && model_fifo.size() == 0 && fifo_cnt == 3'd0); k++) cycle();
    chk("final_drained", 32'({fifo_cnt, 8'(q_rx.size())}), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
